write_debug_dr6_deliver: RTL
============================

# write_debug_dr6_deliver

Consumer side of the write-stage debug detector. Once `wr_debug_prepare` fires, this block captures the latched breakpoint, single-step and task-switch hit registers and builds the new DR6 value. It writes DR6, raises a vector-1 (#DB) request to the exception unit and waits for acknowledge. It then pulses `wr_debug_trap_clear` back to the detector so its accumulators restart.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating delivered-#DB event counter.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_debug_prepare` in 1: one-cycle pulse; the detector's hit registers are valid in the following cycle.
- `wr_debug_code_reg` in 4: code breakpoint hits B3..B0.
- `wr_debug_write_reg` in 4: data-write breakpoint hits.
- `wr_debug_read_reg` in 4: data-read breakpoint hits.
- `wr_debug_step_reg` in 1: single-step trap.
- `wr_debug_task_reg` in 1: task-switch T-bit trap.
- `dr6_in` in 32: current architectural DR6.
- `dr6_write` out 1: one-cycle DR6 write strobe.
- `dr6_value` out 32: DR6 write data, valid while `dr6_write`.
- `dbg_exc_req` out 1: #DB request, level.
- `dbg_exc_vector` out 8: constant 8'd1.
- `dbg_exc_ack` in 1: exception unit accepted the request.
- `wr_debug_trap_clear` out 1: one-cycle pulse that clears the detector's accumulators.
- `dbg_busy` out 1: high in every non-IDLE state; the write stage stalls on it.
- `dbg_events` out CNT_W: count of delivered #DB, saturating.

## Operation
- FSM states: IDLE, CAPTURE, WRITE, REQ, CLEAR.
- **IDLE**
  - `wr_debug_prepare`=1 -> CAPTURE. Otherwise hold.
- **CAPTURE**
  - Register hit = code|write|read (4 bits), step and task.
  - Compose `dr6_next`:
    - bits 31:16 = all ones.
    - bit15 (BT) = `dr6_in`[15] | task.
    - bit14 (BS) = `dr6_in`[14] | step.
    - bit13 (BD) = `dr6_in`[13].
    - bit12 = 0.
    - bits 11:4 = all ones.
    - bits 3:0 = hit. B bits are replaced, not ORed.
  - If hit==0, step==0 and task==0 (spurious), go -> CLEAR with no DR6 write, no request and no count.
  - Otherwise -> WRITE.
- **WRITE**: `dr6_write`=1 and `dr6_value`=`dr6_next` for exactly one cycle -> REQ.
- **REQ**
  - `dbg_exc_req`=1 until `dbg_exc_ack` is sampled high. Ack is accepted in the first REQ cycle.
  - On ack -> CLEAR and increment `dbg_events` unless it is all ones.
- **CLEAR**: `wr_debug_trap_clear`=1 for one cycle -> IDLE.
- `wr_debug_prepare` in any non-IDLE state is ignored. The bench flags it as a protocol error.
- `dbg_exc_ack` outside REQ is ignored.
- `dr6_value` holds its last written value between writes.

## Timing
- Reset values: state IDLE, `dr6_write`=0, `dr6_value`=32'hFFFF0FF0, `dbg_exc_req`=0, `wr_debug_trap_clear`=0, `dbg_busy`=0, `dbg_events`=0. `dbg_exc_vector` is always 1.
- The prepare pulse at cycle T produces:
  - CAPTURE at T+1, sampling the hit registers at T+1.
  - `dr6_write` at T+2.
  - `dbg_exc_req` from T+3.
  - Ack at cycle A gives the clear pulse at A+1 and IDLE at A+2.
  - Minimum total latency: 5 cycles from prepare to IDLE.
- Spurious path: CAPTURE at T+1, clear at T+2, IDLE at T+3.
- `dbg_busy` rises at T+1, combinationally from state. It falls in the IDLE cycle following CLEAR.
- `rst` mid-operation has the following effects:
  - The FSM returns to IDLE next cycle.
  - No further DR6 write or clear pulse is issued.
  - `dbg_events` is zeroed.
- A back-to-back prepare in the first IDLE cycle after CLEAR is accepted.

## Structure
- Shared package/defines:
  - DR6 bit positions (B0-B3, BD=13, BS=14, BT=15).
  - DR6 reserved-ones mask 32'hFFFF0FF0.
  - #DB vector constant 8'd1.
  - FSM state encodings.
- Place the DR6 composition in a purely combinational sub-module `debug_dr6_compose` (inputs `dr6_in`, hit, step, task; output `dr6_next`). It is reusable by the GD-fault path.
- FSM, counter and output registers stay in the top module.

## Test plan
- `dr6_in`=32'hFFFF0FF0, code_reg=4'b0001, prepare pulse; ack on the first REQ cycle -> `dr6_write` at T+2 with 32'hFFFF0FF1, req for 1 cycle, clear pulse at T+4, `dbg_events`=1.
- `dr6_in`=32'hFFFF4FF8 (BS and B3 set), write_reg=4'b0010, task=1 -> `dr6_value`=32'hFFFFCFF2: B bits replaced, BS kept, BT set.
- step=1 only, ack delayed 7 cycles -> `dbg_exc_req` high exactly 8 cycles, `dbg_busy` high throughout, single clear pulse.
- All hit inputs 0 at CAPTURE -> no `dr6_write`, no req, clear at T+2, counter unchanged.
- `rst` asserted during REQ -> next cycle IDLE, req=0, no clear pulse, `dbg_events`=0. A later prepare is delivered normally.
- CNT_W=2 with 5 deliveries -> `dbg_events` saturates at 3. A prepare pulse during REQ -> ignored, exactly one DR6 write.

Source files
------------

// File: rtl/write_debug_dr6_deliver_pkg.sv
// Shared constants and FSM encoding for write-stage #DB delivery.
// DR6 layout, reserved-ones mask and the #DB vector live here.
package write_debug_dr6_deliver_pkg;

  localparam int DR6_B0 = 0;
  localparam int DR6_B1 = 1;
  localparam int DR6_B2 = 2;
  localparam int DR6_B3 = 3;
  localparam int DR6_BD = 13;
  localparam int DR6_BS = 14;
  localparam int DR6_BT = 15;

  localparam logic [31:0] DR6_RSVD_ONES = 32'hFFFF0FF0;
  localparam logic [7:0]  DB_VECTOR     = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WRITE,
    ST_REQ,
    ST_CLEAR
  } dbg_state_e;

endpackage

// File: rtl/debug_dr6_compose.sv
// Builds a new DR6 image from the old value and the latched hits.
// Pure combinational; also used by the GD-fault path.
module debug_dr6_compose
  import write_debug_dr6_deliver_pkg::*;
(
  input  logic [31:0] dr6_in,
  input  logic [3:0]  hit,
  input  logic        step,
  input  logic        task_trap,
  output logic [31:0] dr6_next
);

  logic unused_dr6;
  assign unused_dr6 = ^{dr6_in[31:16], dr6_in[12:0]};

  // B bits are replaced by the new hits; sticky BD/BS/BT accumulate
  always_comb begin
    dr6_next                 = DR6_RSVD_ONES;
    dr6_next[DR6_B3:DR6_B0]  = hit;
    dr6_next[DR6_BD]         = dr6_in[DR6_BD];
    dr6_next[DR6_BS]         = dr6_in[DR6_BS] | step;
    dr6_next[DR6_BT]         = dr6_in[DR6_BT] | task_trap;
  end

endmodule

// File: rtl/write_debug_dr6_deliver.sv
// Write-stage #DB delivery: capture hits, write DR6,
// request vector 1, wait for ack, clear the detector.
module write_debug_dr6_deliver
  import write_debug_dr6_deliver_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_debug_prepare,
  input  logic [3:0]       wr_debug_code_reg,
  input  logic [3:0]       wr_debug_write_reg,
  input  logic [3:0]       wr_debug_read_reg,
  input  logic             wr_debug_step_reg,
  input  logic             wr_debug_task_reg,
  input  logic [31:0]      dr6_in,
  output logic             dr6_write,
  output logic [31:0]      dr6_value,
  output logic             dbg_exc_req,
  output logic [7:0]       dbg_exc_vector,
  input  logic             dbg_exc_ack,
  output logic             wr_debug_trap_clear,
  output logic             dbg_busy,
  output logic [CNT_W-1:0] dbg_events
);

  dbg_state_e  state_q;
  dbg_state_e  state_d;
  logic [3:0]  hit;
  logic        spurious;
  logic [31:0] dr6_next;

  assign hit = wr_debug_code_reg
             | wr_debug_write_reg
             | wr_debug_read_reg;

  assign spurious = (hit == 4'b0000)
                  & ~wr_debug_step_reg
                  & ~wr_debug_task_reg;

  debug_dr6_compose u_compose (
    .dr6_in    (dr6_in),
    .hit       (hit),
    .step      (wr_debug_step_reg),
    .task_trap (wr_debug_task_reg),
    .dr6_next  (dr6_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (wr_debug_prepare) state_d = ST_CAPTURE;
      ST_CAPTURE:
        state_d = spurious ? ST_CLEAR : ST_WRITE;
      ST_WRITE:
        state_d = ST_REQ;
      ST_REQ:
        if (dbg_exc_ack) state_d = ST_CLEAR;
      ST_CLEAR:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Image is latched at capture so it is stable during the write strobe
  always_ff @(posedge clk) begin
    if (rst)
      dr6_value <= DR6_RSVD_ONES;
    else if (state_q == ST_CAPTURE && !spurious)
      dr6_value <= dr6_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      dbg_events <= '0;
    else if (state_q == ST_REQ && dbg_exc_ack
             && dbg_events != {CNT_W{1'b1}})
      dbg_events <= dbg_events + CNT_W'(1);
  end

  assign dr6_write           = (state_q == ST_WRITE);
  assign dbg_exc_req         = (state_q == ST_REQ);
  assign wr_debug_trap_clear = (state_q == ST_CLEAR);
  assign dbg_busy            = (state_q != ST_IDLE);
  assign dbg_exc_vector      = DB_VECTOR;

endmodule
